// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (1 start bit, 8 data bits LSB first, 1 stop bit).
// The tx and busy outputs are registered, so there is no combinational path from
// load or in to the outputs. A load that arrives while busy is high is dropped.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] in,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt,   w_cnt;
  logic [2:0]    r_idx,   w_idx;
  logic [7:0]    r_shift, w_shift;
  logic          r_tx,    w_tx;
  logic          r_busy,  w_busy;
  logic          w_last;

  // The current bit period ends on this cycle.
  assign w_last = (r_cnt == LAST);

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end

  // Next-state logic. The tx value for each new bit is computed here so that the
  // registered tx changes on the same edge as the state.
  always_comb begin
    w_state = r_state;
    w_cnt   = w_last ? '0 : r_cnt + CW'(1);
    w_idx   = r_idx;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_busy  = r_busy;
    unique case (r_state)
      IDLE: begin
        w_cnt  = '0;
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (load) begin
          w_shift = in;
          w_idx   = '0;
          w_state = START;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
        end
      end
      START: begin
        if (w_last) begin
          w_state = DATA;
          w_tx    = r_shift[0];
        end
      end
      DATA: begin
        if (w_last) begin
          w_shift = r_shift >> 1;
          w_idx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state = STOP;
            w_tx    = 1'b1;
          end else begin
            // Bit after the shift is r_shift[1] before it.
            w_tx = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_last) begin
          w_state = IDLE;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule
